// File: rtl/load_issue_unit.sv
// load_issue_unit: picks the oldest ready load from the load queue, issues it to memory, returns its data.
// Also holds lsu_pkg, which defines the load queue entry shared with the queue.
package lsu_pkg;
  parameter int XLEN = 32;
  parameter int ROB_TAG_WIDTH = 32;
  typedef struct packed {
    logic                     valid;
    logic                     address_valid;
    logic                     executed;
    logic                     committed;
    logic                     order_fail;
    logic [XLEN-1:0]          address;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
  } load_queue_entry;
endpackage

module load_issue_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = lsu_pkg::XLEN,
  parameter int ROB_TAG_WIDTH = lsu_pkg::ROB_TAG_WIDTH,
  parameter int LDQ_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  load_queue_entry            load_queue_entries [LDQ_SIZE],
  input  logic [$clog2(LDQ_SIZE)-1:0] head,
  input  logic                       flush,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [XLEN-1:0]            mem_req_addr,
  output logic [ROB_TAG_WIDTH-1:0]   mem_req_tag,
  input  logic                       mem_resp_valid,
  input  logic [ROB_TAG_WIDTH-1:0]   mem_resp_tag,
  input  logic [XLEN-1:0]            mem_resp_data,
  output logic                       load_executed,
  output logic [ROB_TAG_WIDTH-1:0]   load_executed_rob_tag,
  output logic                       load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]   load_succeeded_rob_tag,
  output logic [XLEN-1:0]            load_result_data,
  output logic                       busy
);
  localparam int IW = $clog2(LDQ_SIZE);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
  logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d, succ_tag_q, succ_tag_d;
  logic succ_q, succ_d;
  logic sel_found;
  logic [IW-1:0] sel_idx, idx;
  logic hs, resp_hit;
  function automatic logic eligible(input load_queue_entry e);
    return e.valid && e.address_valid && !e.executed && !e.committed && !e.order_fail;
  endfunction
  // Circular scan from head: the first eligible entry is the oldest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    idx = '0;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      idx = head + IW'(i);
      if (!sel_found && eligible(load_queue_entries[idx])) begin
        sel_found = 1'b1;
        sel_idx = idx;
      end
    end
  end
  assign hs = state_q == REQ && mem_req_ready;
  assign resp_hit = mem_resp_valid && mem_resp_tag == tag_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    tag_d = tag_q;
    succ_d = 1'b0;
    succ_tag_d = succ_tag_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: if (sel_found && !flush) begin
        state_d = REQ;
        addr_d = load_queue_entries[sel_idx].address;
        tag_d = load_queue_entries[sel_idx].rob_tag;
      end
      REQ: state_d = mem_req_ready ? (flush ? DRAIN : WAIT) : (flush ? IDLE : REQ);
      WAIT: begin
        state_d = resp_hit ? IDLE : flush ? DRAIN : WAIT;
        succ_d = resp_hit && !flush;
        succ_tag_d = succ_d ? tag_q : succ_tag_q;
        data_d = succ_d ? mem_resp_data : data_q;
      end
      DRAIN: state_d = resp_hit ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      tag_q <= '0;
      succ_q <= 1'b0;
      succ_tag_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      tag_q <= tag_d;
      succ_q <= succ_d;
      succ_tag_q <= succ_tag_d;
      data_q <= data_d;
    end
  end
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr = addr_q;
  assign mem_req_tag = tag_q;
  assign load_executed = hs;
  assign load_executed_rob_tag = hs ? tag_q : '0;
  assign load_succeeded = succ_q;
  assign load_succeeded_rob_tag = succ_tag_q;
  assign load_result_data = data_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_load_issue_unit.sv
// tb_load_issue_unit: scoreboard bench for load_issue_unit; expected issues and results are queued as stimulus is driven.
module tb_load_issue_unit;
  import lsu_pkg::*;
  localparam int N = 16;
  typedef struct packed {logic [31:0] a; logic [31:0] t;} exp_t;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, ready = 1'b0, resp_valid = 1'b0;
  load_queue_entry ents [N];
  logic [3:0] head = '0;
  logic [31:0] resp_tag = '0, resp_data = '0;
  logic mem_req_valid, load_executed, load_succeeded, busy;
  logic [31:0] mem_req_addr, mem_req_tag, load_executed_rob_tag, load_succeeded_rob_tag, load_result_data;
  int cmp = 0, err = 0;
  exp_t exp_iss[$], exp_suc[$];
  exp_t me;

  load_issue_unit dut (
    .clk(clk), .reset(reset), .load_queue_entries(ents), .head(head), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(ready), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag), .mem_resp_valid(resp_valid), .mem_resp_tag(resp_tag),
    .mem_resp_data(resp_data), .load_executed(load_executed),
    .load_executed_rob_tag(load_executed_rob_tag), .load_succeeded(load_succeeded),
    .load_succeeded_rob_tag(load_succeeded_rob_tag), .load_result_data(load_result_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issue/result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (load_executed) begin
      cmp++;
      if (exp_iss.size() == 0) begin
        err++;
        $display("FAIL issue_unexpected got tag %h want no issue", load_executed_rob_tag);
      end else begin
        me = exp_iss.pop_front();
        if ({mem_req_addr, load_executed_rob_tag} !== {me.a, me.t}) begin
          err++;
          $display("FAIL issue got addr %h tag %h want addr %h tag %h", mem_req_addr, load_executed_rob_tag, me.a, me.t);
        end
      end
    end
    if (load_succeeded) begin
      cmp++;
      if (exp_suc.size() == 0) begin
        err++;
        $display("FAIL result_unexpected got tag %h want no result", load_succeeded_rob_tag);
      end else begin
        me = exp_suc.pop_front();
        if ({load_result_data, load_succeeded_rob_tag} !== {me.a, me.t}) begin
          err++;
          $display("FAIL result got data %h tag %h want data %h tag %h", load_result_data, load_succeeded_rob_tag, me.a, me.t);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ents;
    for (int i = 0; i < N; i++) ents[i] = '0;
  endtask

  task automatic set_ent(input int i, input logic [31:0] a, input logic [31:0] t);
    ents[i] = '0;
    ents[i].valid = 1'b1;
    ents[i].address_valid = 1'b1;
    ents[i].address = a;
    ents[i].rob_tag = t;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    cmp++;
    if (got !== want) begin
      err++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_exec(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = load_executed;
    end
    if (!got) begin
      cmp++;
      err++;
      $display("FAIL %s_timeout got no load_executed want pulse", nm);
    end
  endtask

  task automatic wait_req(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = mem_req_valid;
    end
    if (!got) begin
      cmp++;
      err++;
      $display("FAIL %s_timeout got no mem_req_valid want 1", nm);
    end
  endtask

  // Memory response one cycle wide; idx >= 0 marks that entry executed as the queue would.
  task automatic respond(input int idx, input logic [31:0] t, input logic [31:0] d, input bit expect_it);
    tick;
    if (idx >= 0) ents[idx].executed = 1'b1;
    resp_valid = 1'b1;
    resp_tag = t;
    resp_data = d;
    if (expect_it) exp_suc.push_back('{a: d, t: t});
    tick;
    resp_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_tag", mem_req_tag, 32'd0);
    chk("rst_data", load_result_data, 32'd0);
    chk("rst_pulses", {30'b0, load_executed, load_succeeded}, 32'd0);
    tick;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    tick;
    head = 4'd0;
    ready = 1'b1;
    set_ent(3, 32'h100, 32'd7);
    exp_iss.push_back('{a: 32'h100, t: 32'd7});
    @(negedge clk);
    chk("basic_not_yet", {31'b0, mem_req_valid}, 32'd0);
    @(negedge clk);
    chk("basic_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("basic_req_addr", mem_req_addr, 32'h100);
    chk("basic_req_tag", mem_req_tag, 32'd7);
    respond(3, 32'd7, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("basic_succ_pulse", {31'b0, load_succeeded}, 32'd1);
    @(negedge clk);
    chk("basic_succ_once", {31'b0, load_succeeded}, 32'd0);
    chk("basic_idle", {31'b0, busy}, 32'd0);
    clear_ents;
  endtask

  task automatic test_wrap;
    tick;
    head = 4'd12;
    set_ent(2, 32'h200, 32'd2);
    set_ent(14, 32'hE00, 32'd14);
    exp_iss.push_back('{a: 32'hE00, t: 32'd14});
    exp_iss.push_back('{a: 32'h200, t: 32'd2});
    wait_exec("wrap_first");
    respond(14, 32'd14, 32'h1414_0000, 1'b1);
    wait_exec("wrap_second");
    respond(2, 32'd2, 32'h0202_0202, 1'b1);
    repeat (2) @(negedge clk);
    clear_ents;
    head = 4'd0;
  endtask

  task automatic test_stall;
    tick;
    ready = 1'b0;
    set_ent(5, 32'h500, 32'h55);
    exp_iss.push_back('{a: 32'h500, t: 32'h55});
    wait_req("stall");
    for (int k = 0; k < 5; k++) begin
      chk("stall_addr", mem_req_addr, 32'h500);
      chk("stall_tag", mem_req_tag, 32'h55);
      chk("stall_no_exec", {30'b0, load_executed, mem_req_valid}, 32'd1);
      if (k < 4) @(negedge clk);
    end
    tick;
    ready = 1'b1;
    @(negedge clk);
    chk("stall_exec", {31'b0, load_executed}, 32'd1);
    respond(5, 32'h55, 32'h5555_AAAA, 1'b1);
    repeat (2) @(negedge clk);
    clear_ents;
  endtask

  task automatic test_tag_mismatch;
    tick;
    set_ent(6, 32'h600, 32'd7);
    exp_iss.push_back('{a: 32'h600, t: 32'd7});
    wait_exec("mismatch");
    respond(6, 32'd9, 32'hBAD0_0009, 1'b0);
    @(negedge clk);
    chk("mismatch_wait", {30'b0, busy, load_succeeded}, 32'd2);
    respond(-1, 32'd7, 32'h7777_0007, 1'b1);
    @(negedge clk);
    chk("mismatch_done", {31'b0, busy}, 32'd0);
    clear_ents;
  endtask

  task automatic test_flush;
    tick;
    set_ent(8, 32'h800, 32'h21);
    exp_iss.push_back('{a: 32'h800, t: 32'h21});
    wait_exec("flush_wait");
    tick;
    ents[8].executed = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_busy", {31'b0, busy}, 32'd1);
    respond(-1, 32'h21, 32'h2121_2121, 1'b0);
    @(negedge clk);
    chk("drain_done", {30'b0, busy, load_succeeded}, 32'd0);
    set_ent(9, 32'h900, 32'h22);
    exp_iss.push_back('{a: 32'h900, t: 32'h22});
    wait_exec("after_drain");
    respond(9, 32'h22, 32'h2222_2222, 1'b1);
    repeat (2) @(negedge clk);
    clear_ents;
    tick;
    ready = 1'b0;
    set_ent(10, 32'hA00, 32'h33);
    wait_req("flush_req");
    tick;
    flush = 1'b1;
    ents[10] = '0;
    tick;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_req_drop", {30'b0, mem_req_valid, busy}, 32'd0);
    flush = 1'b1;
    ready = 1'b1;
    set_ent(11, 32'hB00, 32'h3A);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_idle_block", {31'b0, mem_req_valid}, 32'd0);
    end
    exp_iss.push_back('{a: 32'hB00, t: 32'h3A});
    flush = 1'b0;
    wait_exec("after_idle_flush");
    respond(11, 32'h3A, 32'h3A3A_3A3A, 1'b1);
    repeat (2) @(negedge clk);
    clear_ents;
    tick;
    set_ent(12, 32'hC00, 32'h44);
    exp_iss.push_back('{a: 32'hC00, t: 32'h44});
    wait_exec("flush_hit");
    tick;
    ents[12].executed = 1'b1;
    flush = 1'b1;
    resp_valid = 1'b1;
    resp_tag = 32'h44;
    resp_data = 32'h4444_4444;
    tick;
    flush = 1'b0;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("flush_hit_discard", {30'b0, busy, load_succeeded}, 32'd0);
    clear_ents;
  endtask

  task automatic test_async_reset;
    tick;
    ready = 1'b0;
    set_ent(13, 32'hD00, 32'h66);
    wait_req("areset");
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid_busy", {30'b0, mem_req_valid, busy}, 32'd0);
    chk("areset_addr", mem_req_addr, 32'd0);
    clear_ents;
    tick;
    reset = 1'b0;
    respond(-1, 32'h66, 32'h6666_6666, 1'b0);
    @(negedge clk);
    chk("areset_stale_resp", {30'b0, busy, load_succeeded}, 32'd0);
  endtask

  initial begin
    clear_ents;
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_tag_mismatch;
    test_flush;
    test_async_reset;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_iss.size() + exp_suc.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/load_issue_unit.md
Name: load_issue_unit

Overview:
Sits directly downstream of the load queue. Each cycle it scans the queue entries for the oldest load that has a valid address and has not yet executed, and issues it to the data memory interface over a valid/ready handshake. It reports the issue back to the queue as load_executed, then returns the memory response as load_succeeded plus result data. It supports one outstanding load and a flush path that discards in-flight work.

Parameters:
XLEN, 32, data and address width
ROB_TAG_WIDTH, 32, width of ROB tag carried with each load
LDQ_SIZE, 16, number of load queue entries (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load_queue_entries  in  LDQ_SIZE x load_queue_entry (lsu_pkg)  current load queue contents
head  in  $clog2(LDQ_SIZE)  load queue head pointer (oldest entry)
flush  in  1  pipeline flush; abandon any in-flight load
mem_req_valid  out  1  memory read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  request address
mem_req_tag  out  ROB_TAG_WIDTH  ROB tag sent with the request
mem_resp_valid  in  1  memory response valid
mem_resp_tag  in  ROB_TAG_WIDTH  ROB tag of the response
mem_resp_data  in  XLEN  loaded data
load_executed  out  1  one-cycle pulse: load issued to memory
load_executed_rob_tag  out  ROB_TAG_WIDTH  tag of the issued load
load_succeeded  out  1  one-cycle pulse: load data returned
load_succeeded_rob_tag  out  ROB_TAG_WIDTH  tag of the returned load
load_result_data  out  XLEN  data returned, valid with load_succeeded
busy  out  1  state != IDLE

Behaviour:
- Eligible entry: valid && address_valid && !executed && !committed && !order_fail.
- Selection is combinational and starts from head, scanning circularly head, head+1, ... with wrap modulo LDQ_SIZE. The first eligible entry wins. Selection is evaluated only in IDLE.
- FSM states: IDLE, REQ, WAIT, DRAIN. On reset, state=IDLE and all outputs are 0, including mem_req_addr, mem_req_tag and load_result_data.
- IDLE: if any entry is eligible and flush=0, latch its address and rob_tag into the request registers and go to REQ. An entry eligible at cycle t gives mem_req_valid=1 at t+1.
- REQ: mem_req_valid=1. mem_req_addr and mem_req_tag stay stable until the handshake completes.
  - On mem_req_valid && mem_req_ready: load_executed=1 in that same cycle (combinational from the handshake), with load_executed_rob_tag = mem_req_tag. Go to WAIT.
  - Waiting in REQ for ready is unbounded.
- WAIT: on mem_resp_valid && mem_resp_tag==latched tag, register the response. Next cycle load_succeeded=1 for exactly one cycle, with load_succeeded_rob_tag and load_result_data. Go to IDLE.
  - A response with a non-matching tag is ignored and the unit stays in WAIT.
  - The response may arrive in the cycle immediately after the handshake.
- Re-issue hazard: the queue sets executed one cycle after load_executed. Because the unit sits in WAIT until the response, it never re-selects the same entry.
- Flush:
  - In IDLE: no effect beyond blocking selection that cycle.
  - In REQ with no handshake that cycle: mem_req_valid drops next cycle and the unit goes to IDLE. Dropping valid before ready is permitted only on flush.
  - In REQ with a handshake in the same cycle: load_executed still pulses, and the unit goes to DRAIN.
  - In WAIT: go to DRAIN.
  - If flush coincides with a matching response in WAIT, the response is discarded and the unit goes to IDLE; load_succeeded is not pulsed.
- DRAIN: wait for the matching response and discard it (no load_succeeded), then go to IDLE. Further flushes while in DRAIN have no effect.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0. Any outstanding memory response after reset is ignored, because in IDLE responses are ignored.
- busy=1 in REQ, WAIT and DRAIN.

Test Plan:
1. Reset, then entry 3 valid with address_valid, addr=0x100, tag=7, head=0, ready=1 -> mem_req_valid at the cycle after eligibility with addr 0x100 and tag 7; load_executed pulse with tag 7; response data 0xDEADBEEF with tag 7 -> load_succeeded one cycle later, data 0xDEADBEEF.
2. Entries 2 and 14 eligible, head=12 -> entry 14 issues first (wrap-around age order); after executed is set, entry 2 issues.
3. Eligible entry, mem_req_ready low for 5 cycles -> addr and tag held stable, load_executed pulses only on the ready cycle.
4. In WAIT, response with tag 9 while waiting for tag 7 -> ignored; then tag 7 arrives -> load_succeeded with tag 7.
5. Flush asserted in WAIT -> DRAIN; matching response arrives -> no load_succeeded, busy drops; next eligible entry then issues normally.
6. Reset asserted asynchronously mid-REQ -> mem_req_valid and busy go to 0 immediately, without waiting for a clock edge.
